// File: rtl/fp_issue_pkg.sv
// Shared constants, error-flag bit positions and channel-id sizing for the
// floating-point multiplier issue/return controller.
package fp_issue_pkg;

    localparam int DEF_WIDTH    = 64;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_TIMEOUT  = 64;

    localparam int ERR_TIMEOUT_BIT  = 0;
    localparam int ERR_SPURIOUS_BIT = 1;
    localparam int ERR_BITS         = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Channel tags are never narrower than one bit, even for two clients.
    function automatic int chan_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_mult_issue_if.sv
// Client request, multiplier core and result-return signals of the issue controller.
// slave = controller view, master = clients/core/consumer view.
interface fp_mult_issue_if
    import fp_issue_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) ();
    localparam int CW = chan_w(CHANNELS);

    logic [CHANNELS-1:0]       req_valid;
    logic [CHANNELS-1:0]       req_ready;
    logic [CHANNELS*WIDTH-1:0] req_a;
    logic [CHANNELS*WIDTH-1:0] req_b;
    logic [CHANNELS-1:0]       req_square;

    logic [WIDTH-1:0]          core_a;
    logic [WIDTH-1:0]          core_b;
    logic                      core_nd;
    logic                      core_rfd;
    logic [WIDTH-1:0]          core_result;
    logic                      core_rdy;

    logic                      res_valid;
    logic                      res_ready;
    logic [WIDTH-1:0]          res_data;
    logic [CW-1:0]             res_chan;

    logic                      err_timeout;
    logic                      err_spurious;

    modport slave (
        input  req_valid, req_a, req_b, req_square,
        input  core_rfd, core_result, core_rdy,
        input  res_ready,
        output req_ready,
        output core_a, core_b, core_nd,
        output res_valid, res_data, res_chan,
        output err_timeout, err_spurious
    );

    modport master (
        output req_valid, req_a, req_b, req_square,
        output core_rfd, core_result, core_rdy,
        output res_ready,
        input  req_ready,
        input  core_a, core_b, core_nd,
        input  res_valid, res_data, res_chan,
        input  err_timeout, err_spurious
    );

endinterface

// File: rtl/fp_issue_fifo.sv
// Generic first-word-fall-through FIFO with full/empty/count.
// Latency: a push is visible at pop_dat the cycle after it is written.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module fp_issue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    // Memory is cleared on reset so the head reads as zero while empty after reset.
    assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/fp_mult_issue.sv
// Round-robin issue of client multiply requests onto one in-order pipelined core, tagged result return.
// Latency: grant -> core_nd next cycle; core_rdy -> res_valid next cycle (buffer empty).
// Backpressure: req_ready only while core_rfd and a credit (buffer + in-flight < DEPTH) remains.
module fp_mult_issue
    import fp_issue_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_mult_issue_if.slave bus
);
    localparam int CW   = chan_w(CHANNELS);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int WDW  = $clog2(TIMEOUT + 1);

    localparam logic [CNTW:0]  DEPTH_C  = (CNTW+1)'(DEPTH);
    localparam logic [CW:0]    CHAN_C   = (CW+1)'(CHANNELS);
    localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT);

    typedef struct packed {
        logic [CW-1:0]    chan;
        logic [WIDTH-1:0] data;
    } res_t;

    // Arbitration
    logic [CW-1:0]      rr_ptr;
    logic [CW-1:0]      gnt_idx;
    logic               gnt_found;
    logic [CW:0]        cand;
    logic               issue_ok;
    logic               fire;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;

    // Bookkeeping
    logic [CNTW-1:0]    tag_cnt;
    logic [CNTW-1:0]    res_cnt;
    logic [CNTW:0]      occupancy;
    logic               tag_full;
    logic               tag_empty;
    logic               res_full;
    logic               res_empty;
    logic [CW-1:0]      tag_dat;
    logic               ret;
    logic               res_push;
    logic               res_pop;
    res_t               res_in;
    res_t               res_out;
    state_t             st;

    // Watchdog and errors
    logic [WDW-1:0]     wd_cnt;
    logic               wd_run;
    logic [ERR_BITS-1:0] err_q;

    // Every in-flight operation and every buffered result holds one credit.
    assign occupancy = {1'b0, tag_cnt} + {1'b0, res_cnt};
    assign issue_ok  = bus.core_rfd && (occupancy < DEPTH_C);

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr;
        cand      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = {1'b0, rr_ptr} + (CW+1)'(k);
            if (cand >= CHAN_C) begin
                cand = cand - CHAN_C;
            end
            if (!gnt_found && bus.req_valid[cand[CW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (gnt_found && issue_ok) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    assign fire  = gnt_found && issue_ok;
    assign a_sel = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    assign b_sel = bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            bus.core_nd <= 1'b0;
            bus.core_a  <= '0;
            bus.core_b  <= '0;
        end else begin
            bus.core_nd <= fire;
            if (fire) begin
                rr_ptr     <= (gnt_idx == CW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
                bus.core_a <= a_sel;
                bus.core_b <= bus.req_square[gnt_idx] ? a_sel : b_sel;
            end
        end
    end

    // The core returns in issue order, so the oldest tag owns each core_rdy.
    fp_issue_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fire && !tag_full),
        .push_dat (gnt_idx),
        .pop      (ret),
        .pop_dat  (tag_dat),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_cnt)
    );

    assign ret         = bus.core_rdy && !tag_empty;
    assign res_pop     = !res_empty && bus.res_ready;
    assign res_push    = ret && (!res_full || res_pop);
    assign res_in.chan = tag_dat;
    assign res_in.data = bus.core_result;

    fp_issue_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (res_push),
        .push_dat (res_in),
        .pop      (res_pop),
        .pop_dat  (res_out),
        .full     (res_full),
        .empty    (res_empty),
        .count    (res_cnt)
    );

    assign bus.res_valid = !res_empty;
    assign bus.res_data  = res_out.data;
    assign bus.res_chan  = res_out.chan;

    assign st = (tag_empty && res_empty) ? ST_IDLE : ST_BUSY;

    // Only operations still inside the core can starve; a full result buffer cannot.
    assign wd_run = (st == ST_BUSY) && !tag_empty && !bus.core_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= '0;
        end else begin
            if (bus.core_rdy && tag_empty) begin
                err_q[ERR_SPURIOUS_BIT] <= 1'b1;
            end
            if (!wd_run) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == WD_MAX - 1'b1) begin
                    err_q[ERR_TIMEOUT_BIT] <= 1'b1;
                end
            end
        end
    end

    assign bus.err_timeout  = err_q[ERR_TIMEOUT_BIT];
    assign bus.err_spurious = err_q[ERR_SPURIOUS_BIT];

endmodule

// File: tb/tb_fp_mult_issue.sv
// Directed bench for fp_mult_issue: behavioural core model with fixed latency,
// scoreboard queue filled at issue time and drained by an independent result monitor.
module tb_fp_mult_issue;
    import fp_issue_pkg::*;

    localparam int WIDTH    = 64;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 4;
    localparam int TIMEOUT  = 64;
    localparam int LAT      = 10;
    localparam int CW       = chan_w(CHANNELS);

    localparam logic [63:0] F1  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] F2  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] F3  = 64'h4008_0000_0000_0000;
    localparam logic [63:0] F4  = 64'h4010_0000_0000_0000;
    localparam logic [63:0] F6  = 64'h4018_0000_0000_0000;
    localparam logic [63:0] F8  = 64'h4020_0000_0000_0000;
    localparam logic [63:0] F9  = 64'h4022_0000_0000_0000;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    typedef struct {
        logic [CW-1:0] chan;
        logic [63:0]   data;
    } exp_t;

    typedef struct {
        logic [63:0] p;
        int          t;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    int n_total = 0;
    int n_pass  = 0;
    int grants  = 0;
    int tb_ptr  = 0;

    exp_t exp_q[$];
    op_t  core_q[$];
    logic stall = 1'b0;
    logic inject_rdy = 1'b0;

    logic [63:0]         op_a [CHANNELS];
    logic [63:0]         op_b [CHANNELS];
    logic [63:0]         prod [CHANNELS];
    logic [CHANNELS-1:0] sq;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_mult_issue_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    fp_mult_issue #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    function automatic int next_ch(input logic [CHANNELS-1:0] m);
        for (int k = 0; k < CHANNELS; k++) begin
            if (m[(tb_ptr + k) % CHANNELS]) return (tb_ptr + k) % CHANNELS;
        end
        return 0;
    endfunction

    task automatic set_row(input int ch, input logic [63:0] a, input logic [63:0] b,
                           input logic s, input logic [63:0] p);
        op_a[ch] = a;
        op_b[ch] = b;
        sq[ch]   = s;
        prod[ch] = p;
        bus.req_a[ch*WIDTH +: WIDTH] = a;
        bus.req_b[ch*WIDTH +: WIDTH] = b;
        bus.req_square = sq;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        tb_ptr = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_ready"},    64'(bus.req_ready),    64'd0);
        check({tag, "_core_nd"},      64'(bus.core_nd),      64'd0);
        check({tag, "_core_a"},       bus.core_a,            64'd0);
        check({tag, "_core_b"},       bus.core_b,            64'd0);
        check({tag, "_res_valid"},    64'(bus.res_valid),    64'd0);
        check({tag, "_res_data"},     bus.res_data,          64'd0);
        check({tag, "_res_chan"},     64'(bus.res_chan),     64'd0);
        check({tag, "_err_timeout"},  64'(bus.err_timeout),  64'd0);
        check({tag, "_err_spurious"}, 64'(bus.err_spurious), 64'd0);
    endtask

    // Holds mask valid until n transfers are seen; grant order and scoreboard entries come from the bench.
    task automatic issue_n(input logic [CHANNELS-1:0] mask, input int n);
        int got;
        int ec;
        got = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.req_valid = (got < n) ? mask : '0;
            if (got >= n) break;
            #1;
            if (|bus.req_ready) begin
                ec = next_ch(mask);
                check("grant_onehot", 64'(bus.req_ready), 64'(1) << ec);
                exp_q.push_back('{chan: CW'(ec), data: prod[ec]});
                tb_ptr = (ec + 1) % CHANNELS;
                got++;
                grants++;
            end
        end
        if (got < n) check("issue_budget", 64'(got), 64'(n));
        bus.req_valid = '0;
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || core_q.size() != 0) && c < 300) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Core model: fixed latency, in order, holds results while stalled.
    initial begin : core_model
        forever begin
            @(negedge clk);
            if (bus.core_nd === 1'b1) begin
                core_q.push_back('{p: $realtobits($bitstoreal(bus.core_a) * $bitstoreal(bus.core_b)),
                                   t: cyc});
            end
            bus.core_rdy    = 1'b0;
            bus.core_result = '0;
            if (inject_rdy) begin
                bus.core_rdy    = 1'b1;
                bus.core_result = JUNK;
                inject_rdy      = 1'b0;
            end else if (!stall && core_q.size() > 0 && (cyc - core_q[0].t) >= LAT) begin
                bus.core_rdy    = 1'b1;
                bus.core_result = core_q[0].p;
                void'(core_q.pop_front());
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.res_valid && bus.res_ready) begin
                check("res_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("res_data", bus.res_data, e.data);
                    check("res_chan", 64'(bus.res_chan), 64'(e.chan));
                end
            end
        end
    end

    initial begin : guard
        #400000;
        $display("FAIL global_timeout: simulation still running at 400000 ns, limit 400000 ns");
        $fatal(1);
    end

    initial begin : stimulus
        int seen;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_square = '0;
        bus.core_rfd   = 1'b1;
        bus.res_ready  = 1'b1;
        sq             = '0;
        for (int i = 0; i < CHANNELS; i++) set_row(i, F2, F1, 1'b0, F2);

        // Reset state
        @(negedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // No grant without core_rfd
        @(negedge clk);
        bus.core_rfd  = 1'b0;
        bus.req_valid = 4'b0001;
        #1;
        check("rfd_low_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        bus.req_valid = '0;
        bus.core_rfd  = 1'b1;

        // Single request 2.0 * 2.0 on ch0
        set_row(0, F2, F2, 1'b0, F4);
        issue_n(4'b0001, 1);
        #1;
        check("t1_core_nd_hi", 64'(bus.core_nd), 64'd1);
        check("t1_core_a", bus.core_a, F2);
        check("t1_core_b", bus.core_b, F2);
        @(negedge clk);
        #1;
        check("t1_core_nd_lo", 64'(bus.core_nd), 64'd0);
        wait_drain("t1_drain");

        // Round robin across all channels: 2.0 * {1,2,3,4}
        do_reset();
        set_row(0, F2, F1, 1'b0, F2);
        set_row(1, F2, F2, 1'b0, F4);
        set_row(2, F2, F3, 1'b0, F6);
        set_row(3, F2, F4, 1'b0, F8);
        issue_n(4'b1111, 12);
        wait_drain("t2_drain");

        // Credit exhaustion with consumer stalled
        do_reset();
        bus.res_ready = 1'b0;
        grants = 0;
        fork
            issue_n(4'b1111, 5);
            begin
                for (int c = 0; c < 50 && grants < DEPTH; c++) @(negedge clk);
                seen = 0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    #1;
                    if (|bus.req_ready) seen++;
                end
                check("t3_grants_at_stall", 64'(grants), 64'(DEPTH));
                check("t3_ready_while_full", 64'(seen), 64'd0);
                @(negedge clk);
                bus.res_ready = 1'b1;
                @(negedge clk);
                bus.res_ready = 1'b0;
                for (int c = 0; c < 30 && grants < DEPTH + 1; c++) @(negedge clk);
                check("t3_grant_after_pop", 64'(grants), 64'(DEPTH + 1));
            end
        join
        bus.res_ready = 1'b1;
        wait_drain("t3_drain");

        // Squaring on ch2: B ignored
        set_row(2, F3, JUNK, 1'b1, F9);
        issue_n(4'b0100, 1);
        #1;
        check("t4_core_nd", 64'(bus.core_nd), 64'd1);
        check("t4_core_a", bus.core_a, F3);
        check("t4_core_b_is_a", bus.core_b, F3);
        wait_drain("t4_drain");
        set_row(2, F2, F3, 1'b0, F6);

        // Watchdog then spurious return
        do_reset();
        stall = 1'b1;
        set_row(0, F2, F2, 1'b0, F4);
        issue_n(4'b0001, 1);
        repeat (TIMEOUT - 1) @(negedge clk);
        #1;
        check("t5_timeout_before", 64'(bus.err_timeout), 64'd0);
        @(negedge clk);
        #1;
        check("t5_timeout_at", 64'(bus.err_timeout), 64'd1);
        stall = 1'b0;
        wait_drain("t5_drain");
        check("t5_spurious_before", 64'(bus.err_spurious), 64'd0);
        inject_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("t5_spurious_set", 64'(bus.err_spurious), 64'd1);
        check("t5_spurious_no_result", 64'(bus.res_valid), 64'd0);
        check("t5_timeout_sticky", 64'(bus.err_timeout), 64'd1);

        // Reset with three operations in flight
        do_reset();
        set_row(0, F2, F1, 1'b0, F2);
        issue_n(4'b1111, 3);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_zero_outputs("t6_reset");
        exp_q.delete();
        tb_ptr = 0;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (bus.res_valid) seen++;
        end
        check("t6_stale_spurious", 64'(bus.err_spurious), 64'd1);
        check("t6_stale_no_valid", 64'(seen), 64'd0);
        wait_drain("t6_drain");

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp_mult_issue.md
# fp_mult_issue

Parametrised issue/return controller in front of the pipelined floating-point multiplier core (operand pair in with `operation_nd`, result out with `rdy`). Accepts operand requests from up to CHANNELS independent clients, arbitrates them round-robin onto the single core, tracks which channel owns each in-flight operation, and buffers returned products with their channel tag. Adds squaring mode, credit-based back-pressure and a watchdog that the bare core handshake lacks.

## Interface
- WIDTH, 64, operand/result width in bits (64 = double precision)
- CHANNELS, 4, number of requesting clients (2..8)
- DEPTH, 4, result buffer entries; also the maximum in-flight operations (power of two)
- TIMEOUT, 64, cycles without `core_rdy` while operations are in flight before `err_timeout` is raised

- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  CHANNELS  per-channel request
- req_ready  out  CHANNELS  per-channel grant; transfer when valid&ready
- req_a  in  CHANNELS*WIDTH  operand A, channel i at [i*WIDTH +: WIDTH]
- req_b  in  CHANNELS*WIDTH  operand B, same packing
- req_square  in  CHANNELS  1: ignore B, issue A*A
- core_a, core_b  out  WIDTH each  operands to core
- core_nd  out  1  one-cycle new-data strobe to core
- core_rfd  in  1  core ready-for-data
- core_result  in  WIDTH  product from core
- core_rdy  in  1  result valid strobe from core
- res_valid  out  1  buffered result available
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  product
- res_chan  out  clog2(CHANNELS)  originating channel
- err_timeout  out  1  sticky watchdog error
- err_spurious  out  1  sticky: `core_rdy` with nothing in flight

## Operation
- Credits: free = DEPTH − (result buffer occupancy + in-flight count). Issue allowed only when free > 0 and `core_rfd` = 1.
- Arbiter: round-robin over `req_valid`, starting at channel after last granted. At most one `req_ready` bit high per cycle, and only when issue allowed. Pointer advances only on an actual transfer.
- Issue: on transfer, operands registered into `core_a/core_b` (B := A when `req_square`), `core_nd` pulses next cycle; channel id pushed into tag FIFO (DEPTH entries); in-flight count +1.
- Return: core is in-order. On `core_rdy`, pop tag FIFO, push {tag, `core_result`} into result buffer; in-flight −1. Issue and return in same cycle: count unchanged.
- Output: result buffer is a DEPTH-entry FIFO, first-word-fall-through; pop on `res_valid & res_ready`. Simultaneous push and pop at full is legal (credits guarantee no overflow).
- `core_rdy` with tag FIFO empty: result dropped, `err_spurious` set, no other state change.
- Watchdog counter resets on every `core_rdy` or when in-flight = 0; at TIMEOUT, `err_timeout` set. Errors clear only on reset; issue continues regardless.
- States per in-flight bookkeeping only; no top-level FSM beyond IDLE (in-flight = 0, buffer empty) / BUSY, exposed internally for the watchdog.

## Timing
- Reset (rst_n = 0 at a rising edge): `req_ready` = 0, `core_nd` = 0, `core_a/core_b` = 0, `res_valid` = 0, `res_data` = 0, `res_chan` = 0, errors = 0, arbiter pointer = 0, FIFOs empty. Reset mid-operation discards in-flight tags; late `core_rdy` after reset flags `err_spurious`.
- Request accepted cycle t → `core_nd` high cycle t+1 only.
- `core_rdy` cycle r → `res_valid` high cycle r+1 (buffer previously empty).
- `req_ready` is combinational from `req_valid`, credits, `core_rfd`; all other outputs registered.
- Sustained throughput: one issue per cycle while `core_rfd` = 1 and credits remain.

## Structure
- Shared package `fp_issue_pkg`: channel-id width function, error-flag bit positions, default WIDTH/DEPTH constants.
- One sub-module `fp_issue_fifo` (parametrised width/depth, FWFT, full/empty/count), instantiated for tag FIFO and result buffer.
- Round-robin arbiter and watchdog inline.

## Test plan
- Single request ch0, A = B = 64'h4000_0000_0000_0000 (2.0), core model latency 10 → `core_nd` one cycle after grant; res_data = 64'h4010_0000_0000_0000, res_chan = 0.
- All 4 channels valid continuously, core_rfd = 1 → grants 0,1,2,3,0…; results return with res_chan in same order.
- `res_ready` held 0: exactly DEPTH = 4 grants, then all `req_ready` = 0 until one result popped, then one more grant.
- req_square = 1 on ch2 with A = 64'h4008_0000_0000_0000 (3.0), B = garbage → `core_b` = A; result 64'h4022_0000_0000_0000 (9.0), res_chan = 2.
- Core model stalls rdy: `err_timeout` = 1 at exactly TIMEOUT cycles after last issue; inject `core_rdy` with none in flight → `err_spurious` = 1.
- Assert rst_n = 0 with 3 in flight → all outputs zero next cycle; subsequent stale `core_rdy` → `err_spurious` = 1, res_valid stays 0.
